// File: rtl/pc_sequencer_if.sv
// Control and observation bundle for the program-counter sequencer.
// master drives the next-PC controls; slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             enable;
  logic             stall;
  logic [2:0]       sel;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] target;
  logic             exception;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] epc;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output enable, stall, sel, branch_offset, target, exception,
    input  PC, pc_plus_step, epc, redirect, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  enable, stall, sel, branch_offset, target, exception,
    output PC, pc_plus_step, epc, redirect, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential / branch / jump / load / call / ret
// next-PC selection with exception redirect and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [2:0] SelSeq    = 3'b000;
  localparam logic [2:0] SelBranch = 3'b001;
  localparam logic [2:0] SelJump   = 3'b010;
  localparam logic [2:0] SelLoad   = 3'b011;
  localparam logic [2:0] SelCall   = 3'b100;
  localparam logic [2:0] SelRet    = 3'b101;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redirect_q, redirect_d;
  logic             ras_err_q, ras_err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;   // next free slot; top of stack is ptr_q-1
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic             upd;
  logic             push;
  logic             ras_empty;
  logic             ras_full;
  logic [PtrW-1:0]  top_idx;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] tgt_aligned;

  assign pc_plus     = pc_q + WIDTH'(STEP);
  assign tgt_aligned = {bus.target[WIDTH-1:2], 2'b00};
  assign top_idx     = ptr_q - PtrW'(1);
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CntW'(RAS_DEPTH));
  // Exception overrides stall; neither matters without enable.
  assign upd         = bus.enable & (~bus.stall | bus.exception);

  // Next-state selection: exception first, then the sel-coded mode.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    ras_err_d  = 1'b0;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    push       = 1'b0;
    if (upd) begin
      if (bus.exception) begin
        pc_d       = EXC_VECTOR;
        epc_d      = pc_q;
        redirect_d = 1'b1;
      end else begin
        unique case (bus.sel)
          SelBranch: begin
            pc_d       = pc_plus + (bus.branch_offset << 2);
            redirect_d = 1'b1;
          end
          SelJump: begin
            pc_d       = tgt_aligned;
            redirect_d = 1'b1;
          end
          SelLoad: begin
            pc_d       = bus.target;
            redirect_d = 1'b1;
          end
          SelCall: begin
            pc_d       = tgt_aligned;
            redirect_d = 1'b1;
            push       = 1'b1;
            ptr_d      = ptr_q + PtrW'(1);
            // When full the write lands on the oldest slot, so count saturates.
            if (ras_full) begin
              ras_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          SelRet: begin
            redirect_d = 1'b1;
            if (ras_empty) begin
              pc_d      = tgt_aligned;
              ras_err_d = 1'b1;
            end else begin
              pc_d  = ras_mem[top_idx];
              ptr_d = top_idx;
              cnt_d = cnt_q - CntW'(1);
            end
          end
          default: begin
            // SelSeq and the reserved codes
            pc_d = pc_plus;
          end
        endcase
      end
    end
  end

  // Architectural state; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      ras_err_q  <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      ras_err_q  <= ras_err_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Stack storage needs no reset: count/pointer alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[ptr_q] <= pc_plus;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.pc_plus_step = pc_plus;
  assign bus.epc          = epc_q;
  assign bus.redirect     = redirect_q;
  assign bus.ras_err      = ras_err_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;

  // SelSeq is covered by the default branch.
  logic unused_sel_seq;
  assign unused_sel_seq = ^SelSeq;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a queue-based reference model.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_redir;
  logic        m_err;
  logic [31:0] m_ras[$];

  task automatic model_reset();
    m_pc    = 32'h0;
    m_epc   = 32'h0;
    m_redir = 1'b0;
    m_err   = 1'b0;
    m_ras.delete();
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic cyc(input logic en, input logic st, input logic [2:0] s,
                     input logic [31:0] off, input logic [31:0] tgt, input logic exc);
    bus.enable        = en;
    bus.stall         = st;
    bus.sel           = s;
    bus.branch_offset = off;
    bus.target        = tgt;
    bus.exception     = exc;
    m_redir = 1'b0;
    m_err   = 1'b0;
    if (en && (!st || exc)) begin
      if (exc) begin
        m_epc   = m_pc;
        m_pc    = 32'h180;
        m_redir = 1'b1;
      end else begin
        case (s)
          3'd1: begin m_pc = m_pc + 32'd4 + (off << 2); m_redir = 1'b1; end
          3'd2: begin m_pc = tgt & ~32'h3; m_redir = 1'b1; end
          3'd3: begin m_pc = tgt; m_redir = 1'b1; end
          3'd4: begin
            if (m_ras.size() == 4) begin
              void'(m_ras.pop_front());
              m_err = 1'b1;
            end
            m_ras.push_back(m_pc + 32'd4);
            m_pc    = tgt & ~32'h3;
            m_redir = 1'b1;
          end
          3'd5: begin
            m_redir = 1'b1;
            if (m_ras.size() == 0) begin
              m_pc  = tgt & ~32'h3;
              m_err = 1'b1;
            end else begin
              m_pc = m_ras.pop_back();
            end
          end
          default: m_pc = m_pc + 32'd4;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    n_tests++;
    if (bus.PC !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc got %h exp %h", bus.PC, 32'h0);
    end
    n_tests++;
    if ({bus.ras_empty, bus.ras_full, bus.redirect, bus.ras_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 1000",
               {bus.ras_empty, bus.ras_full, bus.redirect, bus.ras_err});
    end
    n_tests++;
    if (bus.epc !== 32'h0) begin
      n_fail++; $display("FAIL reset_epc got %h exp 0", bus.epc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (bus.PC !== exp_pc[i] || bus.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_%0d got pc=%h redir=%b exp pc=%h redir=0", i, bus.PC,
                 bus.redirect, exp_pc[i]);
      end
    end
    n_tests++;
    if (bus.pc_plus_step !== 32'h10) begin
      n_fail++; $display("FAIL seq_pc_plus_step got %h exp 10", bus.pc_plus_step);
    end
  endtask

  task automatic test_branch();
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'h20, 1'b0);
    cyc(1'b1, 1'b0, 3'd1, 32'hFFFF_FFFD, 32'h0, 1'b0);
    n_tests++;
    if (bus.PC !== 32'h18 || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL branch got pc=%h redir=%b exp pc=18 redir=1", bus.PC, bus.redirect);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 3'd2, 32'h0, 32'h999, 1'b0);
      n_tests++;
      if (bus.PC !== 32'h18 || bus.redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_hold_%0d got pc=%h redir=%b exp pc=18 redir=0", i, bus.PC,
                 bus.redirect);
      end
    end
  endtask

  task automatic test_call_ret();
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'h100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h400, 1'b0);
      n_tests++;
      if (bus.PC !== 32'h400 || bus.ras_err !== (i == 4) || bus.ras_full !== (i >= 3)) begin
        n_fail++;
        $display("FAIL call_%0d got pc=%h err=%b full=%b exp pc=400 err=%b full=%b", i,
                 bus.PC, bus.ras_err, bus.ras_full, i == 4, i >= 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h0, 1'b0);
      n_tests++;
      if (bus.PC !== 32'h404 || bus.ras_err !== 1'b0 || bus.redirect !== 1'b1) begin
        n_fail++;
        $display("FAIL ret_%0d got pc=%h err=%b exp pc=404 err=0", i, bus.PC, bus.ras_err);
      end
    end
    n_tests++;
    if (bus.ras_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret_empty got %b exp 1", bus.ras_empty);
    end
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h40, 1'b0);
    n_tests++;
    if (bus.PC !== 32'h40 || bus.ras_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_underflow got pc=%h err=%b exp pc=40 err=1", bus.PC, bus.ras_err);
    end
  endtask

  task automatic test_stall_exc();
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'h50, 1'b0);
    cyc(1'b1, 1'b1, 3'd2, 32'h0, 32'h200, 1'b0);
    n_tests++;
    if (bus.PC !== 32'h50 || bus.redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL stall got pc=%h redir=%b exp pc=50 redir=0", bus.PC, bus.redirect);
    end
    cyc(1'b1, 1'b1, 3'd2, 32'h0, 32'h200, 1'b1);
    n_tests++;
    if (bus.PC !== 32'h180 || bus.epc !== 32'h50 || bus.redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL exception got pc=%h epc=%h exp pc=180 epc=50", bus.PC, bus.epc);
    end
  endtask

  task automatic test_wrap_async_reset();
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'hFFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    n_tests++;
    if (bus.PC !== 32'h0) begin
      n_fail++; $display("FAIL wrap got pc=%h exp 0", bus.PC);
    end
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h300, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    n_tests++;
    if (bus.ras_empty !== 1'b0 || bus.PC !== 32'h304) begin
      n_fail++;
      $display("FAIL pre_reset got pc=%h empty=%b exp pc=304 empty=0", bus.PC, bus.ras_empty);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus.PC !== 32'h0 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got pc=%h empty=%b full=%b exp pc=0 empty=1 full=0", bus.PC,
               bus.ras_empty, bus.ras_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // A ret right after release must see an empty stack.
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h88, 1'b0);
    n_tests++;
    if (bus.PC !== 32'h88 || bus.ras_err !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ret got pc=%h err=%b exp pc=88 err=1", bus.PC, bus.ras_err);
    end
  endtask

  task automatic test_random();
    logic        en, st, exc;
    logic [2:0]  s;
    logic [31:0] off, tgt;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      st  = ($urandom_range(0, 9) < 2);
      exc = ($urandom_range(0, 19) == 0);
      s   = 3'($urandom_range(0, 7));
      off = 32'($signed($urandom_range(0, 64)) - 32);
      tgt = $urandom();
      cyc(en, st, s, off, tgt, exc);
      n_tests++;
      if (bus.PC !== m_pc || bus.pc_plus_step !== m_pc + 32'd4 || bus.epc !== m_epc ||
          bus.redirect !== m_redir || bus.ras_err !== m_err ||
          bus.ras_empty !== (m_ras.size() == 0) || bus.ras_full !== (m_ras.size() == 4)) begin
        n_fail++;
        $display("FAIL random_%0d got pc=%h epc=%h redir=%b err=%b e=%b f=%b exp pc=%h epc=%h redir=%b err=%b n=%0d",
                 i, bus.PC, bus.epc, bus.redirect, bus.ras_err, bus.ras_empty, bus.ras_full,
                 m_pc, m_epc, m_redir, m_err, m_ras.size());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.enable        = 1'b0;
    bus.stall         = 1'b0;
    bus.sel           = 3'd0;
    bus.branch_offset = 32'h0;
    bus.target        = 32'h0;
    bus.exception     = 1'b0;
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_stall_exc();
    test_wrap_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the PC/address width (>=8).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0180, meaning the PC value loaded on exception.
REQ-004 SHALL have parameter STEP, default 4, meaning the sequential increment.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, meaning the return-address-stack entries (power of two, >=2).
REQ-006 SHALL have port clk  input  1  system clock, rising edge active.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port enable  input  1  permits PC update this cycle.
REQ-009 SHALL have port stall  input  1  holds PC and RAS (ignored for exception).
REQ-010 SHALL have port sel  input  3  next-PC mode: 000 seq, 001 branch, 010 jump, 011 load, 100 call, 101 ret.
REQ-011 SHALL have port branch_offset  input  WIDTH  signed word offset for branch.
REQ-012 SHALL have port target  input  WIDTH  jump/load/call target, ret fallback.
REQ-013 SHALL have port exception  input  1  redirect to EXC_VECTOR.
REQ-014 SHALL have port PC  output  WIDTH  current program counter (registered).
REQ-015 SHALL have port pc_plus_step  output  WIDTH  combinational PC+STEP.
REQ-016 SHALL have port epc  output  WIDTH  PC captured at the last exception (registered).
REQ-017 SHALL have port redirect  output  1  registered, high for one cycle after any non-seq update.
REQ-018 SHALL have port ras_empty / ras_full  output  1 each  RAS occupancy flags (registered state).
REQ-019 SHALL have port ras_err  output  1  registered one-cycle pulse on RAS overflow or underflow.

Function
REQ-020 An update SHALL occur at a rising clk only when enable=1 and (stall=0 or exception=1); otherwise PC, RAS, epc hold and redirect/ras_err go 0.
REQ-021 Priority SHALL be exception > stall > sel.
REQ-022 Exception: PC <= EXC_VECTOR, epc <= current PC, RAS unchanged, redirect <= 1.
REQ-023 seq (000) and reserved codes 110/111: PC <= PC+STEP, redirect <= 0.
REQ-024 branch (001): PC <= PC + STEP + (sign-extended branch_offset << 2), redirect <= 1.
REQ-025 jump (010) and load (011): PC <= target with bits [1:0] forced to 0 for jump, target unmodified for load; redirect <= 1.
REQ-026 call (100): PC <= target with [1:0] forced 0; push PC+STEP onto RAS; redirect <= 1.
REQ-027 ret (101), RAS not empty: PC <= top entry, pop; redirect <= 1.
REQ-028 ret, RAS empty: PC <= target with [1:0] forced 0, RAS unchanged, ras_err <= 1, redirect <= 1.
REQ-029 call with RAS full: oldest entry discarded (circular overwrite), occupancy stays RAS_DEPTH, ras_full stays 1, ras_err <= 1.
REQ-030 All PC arithmetic SHALL be modulo 2^WIDTH (wrap from all-ones+STEP to low values, no flag).
REQ-031 ras_empty SHALL equal (count==0), ras_full SHALL equal (count==RAS_DEPTH); count width clog2(RAS_DEPTH)+1.
REQ-032 Latency: PC SHALL reflect the selected next value one clock after the enabling edge; pc_plus_step SHALL follow PC combinationally.

Reset
REQ-033 reset=0 SHALL immediately (without clk) force PC=RESET_VECTOR, epc=0, redirect=0, ras_err=0, RAS count=0 (ras_empty=1, ras_full=0).
REQ-034 Reset asserted mid-operation SHALL discard all RAS contents; first update after release (reset=1, enable=1) SHALL start from RESET_VECTOR.
REQ-035 RAS storage entries need no reset; only count/pointer SHALL be reset.

Verification
REQ-036 Reset then 3 cycles seq, enable=1 -> PC 0x0, 0x4, 0x8, 0xC; redirect=0 throughout.
REQ-037 PC=0x20, branch, offset=-3 -> PC=0x18, redirect=1 for one cycle; enable=0 next cycles -> PC holds 0x18.
REQ-038 PC=0x100, call target 0x400 x5 (nested, RAS_DEPTH=4) -> 5th call sets ras_err=1, ras_full=1; 4 rets return 0x404,0x404,0x404,0x404 in reverse push order, then ras_empty=1; 5th ret with target 0x40 -> PC=0x40, ras_err=1.
REQ-039 stall=1 with sel=jump target 0x200 -> PC unchanged; exception=1 same cycle with PC=0x50 -> PC=0x180, epc=0x50.
REQ-040 PC=0xFFFF_FFFC, seq -> PC=0x0000_0000; then reset=0 asynchronously mid-cycle with RAS non-empty -> PC=0x0, ras_empty=1 before next clk edge.
